// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR conversion controller.
// sar_ideal_code gives the code a perfect SAR converter returns for a given input voltage.
package sar_pkg;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} sar_state_t;

    localparam int SAR_WIDTH = 8;

    // Largest code whose reference level (code*vref/2^width) does not exceed vin.
    function automatic int sar_ideal_code(real vin, real vref, int width);
        int  top;
        real x;
        top = (1 << width) - 1;
        x   = vin / vref * real'(top + 1);
        if (x <= 0.0) return 0;
        if (x >= real'(top)) return top;
        return int'($floor(x));
    endfunction

endpackage

// File: rtl/sar_controller.sv
// Successive-approximation control FSM: sample, one bit trial per settle window, start/done handshake.
// Drives the reference-mux select and captures the comparator decision at the end of each trial.
module sar_controller
    import sar_pkg::*;
#(
    parameter int width         = SAR_WIDTH,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp,
    output logic             sample,
    output logic [width-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] result
);

    localparam int KW = (width > 1) ? $clog2(width) : 1;

    sar_state_t       state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic [KW-1:0]    k, k_n, km1;
    logic [width-1:0] code_n, res_n, trial;
    logic             sample_n, busy_n, done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            k        <= '0;
            dac_code <= '0;
            result   <= '0;
            sample   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            k        <= k_n;
            dac_code <= code_n;
            result   <= res_n;
            sample   <= sample_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        k_n      = k;
        km1      = k - KW'(1);
        code_n   = dac_code;
        res_n    = result;
        sample_n = sample;
        busy_n   = busy;
        done_n   = 1'b0;
        trial    = dac_code;
        case (state)
            IDLE: begin
                sample_n = 1'b0;
                busy_n   = 1'b0;
                if (start) begin
                    state_n  = SAMPLE;
                    sample_n = 1'b1;
                    busy_n   = 1'b1;
                    cnt_n    = '0;
                end
            end
            SAMPLE: begin
                if (cnt == 8'(SAMPLE_CYCLES - 1)) begin
                    state_n           = CONVERT;
                    sample_n          = 1'b0;
                    cnt_n             = '0;
                    k_n               = KW'(width - 1);
                    code_n            = '0;
                    code_n[width-1]   = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            CONVERT: begin
                // Comparator is only looked at on the edge closing the trial's last settle cycle.
                if (cnt == 8'(SETTLE_CYCLES - 1)) begin
                    cnt_n = '0;
                    if (!cmp) trial[k] = 1'b0;
                    if (k != '0) begin
                        trial[km1] = 1'b1;
                        k_n        = km1;
                    end else begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        res_n   = trial;
                    end
                    code_n = trial;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/sar_controller.md
Name: sar_controller

Overview:
- Successive-approximation control FSM for the SAR ADC data path.
- Drives the reference-select code (`dac_code`) into the existing DAC/reference mux, so it is the control-side end of that mux interface.
- Samples the comparator decision once per bit trial and returns the converted code with a start/done handshake.
- Sits between the column readout sequencer (start/done side) and the analog mux plus comparator (`dac_code`/`cmp` side).

Parameters:
- `width`, 8: resolution in bits; equals the select width of the reference mux.
- `SAMPLE_CYCLES`, 2: cycles `sample` is held high (S/H acquisition); legal 1..255.
- `SETTLE_CYCLES`, 1: cycles per bit trial, for DAC/mux settling and comparator decision; legal 1..255.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  conversion request; honoured only in IDLE.
- `cmp`  in  1  comparator output; 1 = Vin >= Vdac(`dac_code`).
- `sample`  out  1  S/H enable, high during acquisition.
- `dac_code`  out  width  trial code to the reference mux select.
- `busy`  out  1  high from acceptance of start until DONE is entered.
- `done`  out  1  one-cycle pulse; `result` is valid from that cycle.
- `result`  out  width  last completed conversion; held until the next done.

Behaviour:
- **Reset** (`rst_n`=0, async, any state): state=IDLE; `sample`=0, `dac_code`=0, `busy`=0, `done`=0, `result`=0; counters cleared. A conversion in progress is discarded, with no done pulse.
- **States:** IDLE, SAMPLE, CONVERT, DONE; all outputs are registered.
- **IDLE:**
  - `busy`=0, `sample`=0, `dac_code` holds its last value.
  - `start`=1 at an edge → SAMPLE; from that edge `busy`=1 and `sample`=1.
- **SAMPLE:**
  - `sample`=1 for exactly `SAMPLE_CYCLES` cycles; `cmp` is ignored.
  - On the last cycle's edge → CONVERT, with `sample`=0, `dac_code`=1<<(width-1), bit index k=width-1, settle count=0.
- **CONVERT, per trial:**
  - `dac_code` is held for `SETTLE_CYCLES` cycles; `cmp` is sampled only at the edge ending the trial's final cycle.
  - `cmp`=0 clears bit k; `cmp`=1 keeps it.
  - If k>0, bit k-1 is also set in the same update and k decrements.
  - If k=0, go to DONE with `result` <= final code and `dac_code` <= the same final code.
- **DONE:** one cycle with `done`=1 and `busy`=0, then → IDLE unconditionally.
- **Latency:** `start` sampled at edge N puts `done` high in the cycle following edge N+`SAMPLE_CYCLES`+`width`*`SETTLE_CYCLES`.
- **Throughput:** the next start is accepted at the edge after the DONE cycle, giving a minimum period of `SAMPLE_CYCLES`+`width`*`SETTLE_CYCLES`+2 cycles.
- **start outside IDLE** (SAMPLE/CONVERT/DONE): ignored, not queued.
- **start held high continuously:** back-to-back conversions, each separated by one IDLE cycle.
- **cmp changes mid-trial:** no effect except at the sampling edge.
- **Boundary codes:**
  - `cmp` always 1 → `result`=2^width-1.
  - `cmp` always 0 → `result`=0.
  - Neither case overflows; the bit index stops at 0.
- **Arithmetic:** k counter is $clog2(width) bits; cycle counter is 8 bits. No arithmetic on `dac_code`, only bit set/clear.

Decomposition:
- Package `sar_pkg`:
  - state enum `sar_state_t` {IDLE, SAMPLE, CONVERT, DONE};
  - localparam default resolution;
  - function `sar_ideal_code(real vin, real vref, int width)` for benches.
- Single module; no sub-module needed.
- The bench reuses the existing MUX with `$realtobits` reference levels plus a behavioural comparator (`cmp` = vin >= selected level).

Test Plan:
1. **Directed conversion:** width=4, S=2, T=1, comparator model with vin code 10. Start pulse at edge 0 → `dac_code` sequence 8,12,10,11; `done` in the cycle after edge 6; `result`=10; `busy` high for 6 cycles.
2. **Extremes:** width=8, `cmp` tied 1 → `result`=255; `cmp` tied 0 → `result`=0. `done` at N+2+8 in both cases.
3. **Settle timing:** T=3, `cmp` toggled on the non-final cycles of each trial. Only the final-cycle value affects `result`; latency is N+2+24.
4. **Handshake:** `start` re-pulsed during SAMPLE and CONVERT → ignored, exactly one done. `start` held high → conversions every S+width*T+2 cycles; `result` updates only on `done`.
5. **Reset mid-CONVERT:** assert `rst_n`=0 asynchronously at trial 2. All outputs go 0 immediately, with no done. After release, a new start converts correctly (code 0xA5 → `result`=0xA5).
6. **Randomised sweep:** 200 random vin across the mux reference levels. `result` equals `sar_ideal_code` every time.
